lane_shift_reg: RTL and testbench
=================================

Name: lane_shift_reg

Overview:
Parametrised universal shift register for the FFT datapath. It generalises the 1-bit serial-in/parallel-out right shifter to DEPTH lanes of LANE_W bits each. It supports right shift, left shift, hold and parallel load, with serial outputs at both ends and a word-complete pulse. It sits between the serial sample stream and butterfly inputs (SIPO), and between butterfly outputs and the serial stream (PISO).

Parameters:
LANE_W, 1, bits per lane (bits moved per shift); must be >= 1
DEPTH, 4, number of lanes; must be >= 2
W, LANE_W*DEPTH, derived total register width; not overridable
CNT_W, clog2(DEPTH), derived counter width; not overridable

Ports:
clk  in  1  rising-edge clock
clr_n  in  1  asynchronous active-low reset
clr  in  1  synchronous active-high clear; overrides en and mode
en  in  1  operation enable; 0 forces hold
mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
s_in_r  in  LANE_W  lane entering the top lane (DEPTH-1) on a right shift
s_in_l  in  LANE_W  lane entering lane 0 on a left shift
pin  in  W  parallel load data
dout  out  W  register contents; lane k = dout[k*LANE_W +: LANE_W]
s_out_r  out  LANE_W  lane 0 of dout (combinational from the register)
s_out_l  out  LANE_W  lane DEPTH-1 of dout (combinational from the register)
cnt  out  CNT_W  shifts completed in the current word, 0..DEPTH-1
word_done  out  1  one-cycle pulse: dout holds DEPTH freshly shifted lanes

Behaviour:
- Reset: clr_n=0 asynchronously forces dout=0, cnt=0, word_done=0, regardless of clk.
- Priority at each rising clk edge: clr > (en=0 or mode=00) > mode action.
- clr=1: dout<=0, cnt<=0, word_done<=0.
- Hold (en=0 or mode=00): dout and cnt unchanged; word_done<=0.
- Right shift (01): dout <= {s_in_r, dout[W-1:LANE_W]}; lane 0 is discarded (visible on s_out_r before the edge).
- Left shift (10): dout <= {dout[W-LANE_W-1:0], s_in_l}; the top lane is discarded (visible on s_out_l before the edge).
- Load (11): dout <= pin; cnt <= 0; word_done <= 0.
- Shift counting: every executed shift in either direction increments cnt.
  - When cnt==DEPTH-1, cnt wraps to 0 and word_done<=1 on the same edge.
  - In all other cases word_done<=0.
- Latency: zero added latency. dout, cnt and word_done all update on the same edge as the triggering operation.
- Changing direction mid-word does not reset cnt. Only load, clr and clr_n reset it.
- word_done never stays high for two consecutive cycles unless DEPTH consecutive shifts complete each cycle. With DEPTH>=2 it is always a single-cycle pulse.
- Reset asserted mid-word discards the partial word. After release, the first shift is counted as shift 1.
- All internal state is nonblocking-assigned in a single clocked process. No initial blocks; reset is the only initialisation.

Decomposition:
- Shared package fft_pkg holds the mode encodings MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD (2-bit constants) and a clog2 helper.
- Natural sub-module: lane_shift_cnt, the modulo-DEPTH shift counter that generates word_done. It is instantiated once. The data register stays in the top level.

Test Plan:
- LANE_W=1, DEPTH=4: reset, then right shift s_in_r=1,0,1,1 over 4 cycles -> dout 1000, 0100, 1010, 1101; cnt 1,2,3,0; word_done=1 only after the 4th edge.
- LANE_W=1, DEPTH=4: load pin=1001, then left shift with s_in_l=0 -> s_out_l=1 before the edge; dout=0010 and cnt=1 after it.
- LANE_W=8, DEPTH=4: right shift 0x11,0x22,0x33,0x44 -> dout=0x44332211 with word_done pulse. Next shift of 0x55 -> dout=0x55443322, cnt=1, word_done=0.
- en=0 with mode=01 for 3 cycles mid-word -> dout and cnt frozen, word_done=0. Resuming completes the word after the remaining shifts.
- clr=1 together with mode=11 and pin=0xFF (LANE_W=2, DEPTH=4) -> dout=0, cnt=0. clr wins over load.
- clr_n pulsed low between clock edges with cnt=2 -> dout=0 and cnt=0 immediately. After release, 4 right shifts are needed for word_done.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: shift-register mode encodings and a
// ceiling-log2 helper used to size lane counters.
package fft_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Ceiling log2, never below 1, so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lane_shift_reg_if.sv
// Control and data bundle of the lane shift register; master drives the
// controls and data in, slave is the register itself.
interface lane_shift_reg_if
  import fft_pkg::*;
#(
    parameter int LANE_W = 1,
    parameter int DEPTH  = 4
);
    localparam int W     = LANE_W * DEPTH;
    localparam int CNT_W = clog2(DEPTH);

    logic              clr;
    logic              en;
    logic [1:0]        mode;
    logic [LANE_W-1:0] s_in_r;
    logic [LANE_W-1:0] s_in_l;
    logic [W-1:0]      pin;
    logic [W-1:0]      dout;
    logic [LANE_W-1:0] s_out_r;
    logic [LANE_W-1:0] s_out_l;
    logic [CNT_W-1:0]  cnt;
    logic              word_done;

    modport master (
        output clr, en, mode, s_in_r, s_in_l, pin,
        input  dout, s_out_r, s_out_l, cnt, word_done
    );

    modport slave (
        input  clr, en, mode, s_in_r, s_in_l, pin,
        output dout, s_out_r, s_out_l, cnt, word_done
    );

endinterface

// File: rtl/lane_shift_cnt.sv
// Modulo-DEPTH shift counter; pulses word_done on the edge that completes
// DEPTH shifts and wraps the count back to zero.
module lane_shift_cnt #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             word_done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the ifs leaves a variable unassigned and infers a latch.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clr_i || load_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign word_done_o = done_q;

endmodule

// File: rtl/lane_shift_reg.sv
// Universal multi-lane shift register (SIPO/PISO) between the serial sample
// stream and the FFT butterflies; holds the data, delegates word counting.
module lane_shift_reg
  import fft_pkg::*;
#(
    parameter int LANE_W = 1,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                clr_n,
    lane_shift_reg_if.slave     bus
);

    localparam int W     = LANE_W * DEPTH;
    localparam int CNT_W = clog2(DEPTH);

    logic [W-1:0] dout_q, dout_d;
    logic         do_shift;
    logic         do_load;

    // Synchronous clear beats everything; en=0 behaves exactly like MODE_HOLD.
    always_comb begin
        dout_d   = dout_q;
        do_shift = 1'b0;
        do_load  = 1'b0;
        if (bus.clr) begin
            dout_d = '0;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_SHR: begin
                    dout_d   = {bus.s_in_r, dout_q[W-1:LANE_W]};
                    do_shift = 1'b1;
                end
                MODE_SHL: begin
                    dout_d   = {dout_q[W-LANE_W-1:0], bus.s_in_l};
                    do_shift = 1'b1;
                end
                MODE_LOAD: begin
                    dout_d  = bus.pin;
                    do_load = 1'b1;
                end
                default: dout_d = dout_q;
            endcase
        end
    end

    // NOTE: only clr_n initialises the register; there are no memories here
    // whose contents would need to survive or be exempt from reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) dout_q <= '0;
        else        dout_q <= dout_d;
    end

    lane_shift_cnt #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk         (clk),
        .clr_n       (clr_n),
        .clr_i       (bus.clr),
        .load_i      (do_load),
        .shift_i     (do_shift),
        .cnt_o       (bus.cnt),
        .word_done_o (bus.word_done)
    );

    assign bus.dout    = dout_q;
    assign bus.s_out_r = dout_q[LANE_W-1:0];
    assign bus.s_out_l = dout_q[W-1 -: LANE_W];

endmodule

// File: tb/tb_lane_shift_reg.sv
// Bench for lane_shift_reg: directed literal checks on a 1-bit and an 8-bit
// lane instance, plus a lane-array model compared against the 8-bit one every cycle.
module tb_lane_shift_reg;
  import fft_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic clr_n;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_b    = 0;

  lane_shift_reg_if #(.LANE_W(1), .DEPTH(DEPTH)) bus_a ();
  lane_shift_reg_if #(.LANE_W(8), .DEPTH(DEPTH)) bus_b ();

  lane_shift_reg #(.LANE_W(1), .DEPTH(DEPTH)) u_a (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus_a)
  );

  lane_shift_reg #(.LANE_W(8), .DEPTH(DEPTH)) u_b (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model of the 8-bit instance: an array of lanes and a count of
  // shifts taken in the current word.
  logic [7:0] m_lane [DEPTH] = '{default: 8'h00};
  int         m_cnt          = 0;
  bit         m_wd           = 0;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n || bus_b.clr) begin
      for (int k = 0; k < DEPTH; k++) m_lane[k] <= 8'h00;
      m_cnt <= 0;
      m_wd  <= 0;
    end else if (!bus_b.en || bus_b.mode == MODE_HOLD) begin
      m_wd <= 0;
    end else if (bus_b.mode == MODE_LOAD) begin
      for (int k = 0; k < DEPTH; k++) m_lane[k] <= bus_b.pin[k*8 +: 8];
      m_cnt <= 0;
      m_wd  <= 0;
    end else begin
      if (bus_b.mode == MODE_SHR) begin
        for (int k = 0; k < DEPTH - 1; k++) m_lane[k] <= m_lane[k+1];
        m_lane[DEPTH-1] <= bus_b.s_in_r;
      end else begin
        for (int k = 1; k < DEPTH; k++) m_lane[k] <= m_lane[k-1];
        m_lane[0] <= bus_b.s_in_l;
      end
      m_cnt <= (m_cnt + 1) % DEPTH;
      m_wd  <= (m_cnt + 1 == DEPTH);
    end
  end

  function automatic logic [31:0] m_pack();
    logic [31:0] r;
    for (int k = 0; k < DEPTH; k++) r[k*8 +: 8] = m_lane[k];
    return r;
  endfunction

  bit prev_wd = 0;
  always @(negedge clk) begin
    if (chk_b) begin
      check("b_dout",    bus_b.dout,      m_pack());
      check("b_cnt",     bus_b.cnt,       m_cnt[1:0]);
      check("b_wd",      bus_b.word_done, m_wd);
      check("b_s_out_r", bus_b.s_out_r,   m_lane[0]);
      check("b_s_out_l", bus_b.s_out_l,   m_lane[DEPTH-1]);
      check("b_wd_pulse", prev_wd & bus_b.word_done, 1'b0);
      prev_wd = bus_b.word_done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_b(input logic en, input logic [1:0] mode, input logic [7:0] sr,
                       input logic [7:0] sl, input logic [31:0] pin);
    bus_b.en = en; bus_b.mode = mode; bus_b.s_in_r = sr; bus_b.s_in_l = sl; bus_b.pin = pin;
  endtask

  logic [3:0] a_dout_exp [4] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
  logic       a_sin      [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0] a_cnt_exp  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic       a_wd_exp   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       a_tail_sin [3] = '{1'b0, 1'b0, 1'b1};
  logic [3:0] a_tail_exp [3] = '{4'b0001, 4'b0000, 4'b1000};
  logic [7:0] b_bytes    [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    clr_n = 1'b0;
    bus_a.clr = 0; bus_a.en = 0; bus_a.mode = MODE_HOLD;
    bus_a.s_in_r = 0; bus_a.s_in_l = 0; bus_a.pin = '0;
    bus_b.clr = 0;
    set_b(0, MODE_HOLD, 8'h00, 8'h00, 32'h0);
    chk_b = 1;
    #12;
    check("a_reset_dout", bus_a.dout, 4'b0000);
    check("a_reset_cnt",  bus_a.cnt, 2'd0);
    check("a_reset_wd",   bus_a.word_done, 1'b0);
    check("b_reset_dout", bus_b.dout, 32'h0);
    clr_n = 1'b1;

    // 1-bit lanes: right shift 1,0,1,1 completes one word.
    bus_a.en = 1; bus_a.mode = MODE_SHR;
    for (int i = 0; i < 4; i++) begin
      bus_a.s_in_r = a_sin[i];
      step();
      check("a_shr_dout", bus_a.dout, a_dout_exp[i]);
      check("a_shr_cnt",  bus_a.cnt, a_cnt_exp[i]);
      check("a_shr_wd",   bus_a.word_done, a_wd_exp[i]);
    end

    // Load then left shift: top lane visible before the edge.
    bus_a.mode = MODE_LOAD; bus_a.pin = 4'b1001;
    step();
    check("a_load_dout", bus_a.dout, 4'b1001);
    check("a_load_cnt",  bus_a.cnt, 2'd0);
    check("a_load_wd",   bus_a.word_done, 1'b0);
    bus_a.mode = MODE_SHL; bus_a.s_in_l = 0;
    #1;
    check("a_s_out_l_pre", bus_a.s_out_l, 1'b1);
    check("a_s_out_r_pre", bus_a.s_out_r, 1'b1);
    step();
    check("a_shl_dout", bus_a.dout, 4'b0010);
    check("a_shl_cnt",  bus_a.cnt, 2'd1);

    // en=0 with a shift mode freezes everything; resuming finishes the word.
    bus_a.en = 0; bus_a.mode = MODE_SHR; bus_a.s_in_r = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("a_hold_dout", bus_a.dout, 4'b0010);
      check("a_hold_cnt",  bus_a.cnt, 2'd1);
      check("a_hold_wd",   bus_a.word_done, 1'b0);
    end
    bus_a.en = 1;
    for (int i = 0; i < 3; i++) begin
      bus_a.s_in_r = a_tail_sin[i];
      step();
      check("a_tail_dout", bus_a.dout, a_tail_exp[i]);
      check("a_tail_wd",   bus_a.word_done, i == 2);
    end
    bus_a.mode = MODE_HOLD;
    step();
    check("a_wd_drop", bus_a.word_done, 1'b0);
    bus_a.en = 0;

    // 8-bit lanes: byte word assembly and the first shift of the next word.
    for (int i = 0; i < 4; i++) begin
      set_b(1, MODE_SHR, b_bytes[i], 8'h00, 32'h0);
      step();
    end
    check("b_word_dout", bus_b.dout, 32'h44332211);
    check("b_word_wd",   bus_b.word_done, 1'b1);
    set_b(1, MODE_SHR, 8'h55, 8'h00, 32'h0);
    step();
    check("b_next_dout", bus_b.dout, 32'h55443322);
    check("b_next_cnt",  bus_b.cnt, 2'd1);
    check("b_next_wd",   bus_b.word_done, 1'b0);

    // Synchronous clear wins over a load.
    bus_b.clr = 1;
    set_b(1, MODE_LOAD, 8'h00, 8'h00, 32'h000000FF);
    step();
    bus_b.clr = 0;
    check("b_clr_dout", bus_b.dout, 32'h0);
    check("b_clr_cnt",  bus_b.cnt, 2'd0);

    // Asynchronous reset mid-word discards the partial count.
    set_b(1, MODE_SHR, 8'h77, 8'h00, 32'h0);
    step();
    step();
    check("b_pre_rst_cnt", bus_b.cnt, 2'd2);
    set_b(0, MODE_HOLD, 8'h00, 8'h00, 32'h0);
    clr_n = 0;
    #2;
    check("b_arst_dout", bus_b.dout, 32'h0);
    check("b_arst_cnt",  bus_b.cnt, 2'd0);
    check("a_arst_cnt",  bus_a.cnt, 2'd0);
    clr_n = 1;
    for (int i = 0; i < 4; i++) begin
      set_b(1, MODE_SHR, 8'hA1 + 8'(i), 8'h00, 32'h0);
      step();
      check("b_post_rst_wd", bus_b.word_done, i == 3);
    end
    check("b_post_rst_dout", bus_b.dout, 32'hA4A3A2A1);

    // Randomised traffic, shift-heavy, with rare clears and reset pulses.
    repeat (400) begin
      bus_b.clr = ($urandom_range(31) == 0);
      set_b($urandom_range(7) != 0,
            ($urandom_range(9) < 7) ? 2'($urandom_range(1, 2)) : 2'($urandom_range(3)),
            8'($urandom), 8'($urandom), $urandom);
      if ($urandom_range(63) == 0) begin
        clr_n = 0;
        #1;
        clr_n = 1;
      end
      step();
    end

    chk_b = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
